phy_link_ctrl: RTL and testbench
================================

// Module: phy_link_ctrl
// PURPOSE
//  Link-training sequencer for the two-lane PHY (phy_tx/phy_rx pair). Brings lanes up in order
//  (lane0, then lane1), confirms each via the RX-side active0/active1 flags, then gates valid_in
//  into the TX. Detects lane loss, retrains up to MAX_RETRY times, otherwise latches an error.
//  Sits beside phy, in the clk_f domain, driving phy active_lane0/active_lane1 and valid_in.
// PARAMETERS
//  STABLE_CYC  4    consecutive cycles an rx_active flag must be high to count as locked; also quiet time
//  TIMEOUT     200  max cycles allowed in one TRAIN state before retry
//  TMR_W       8    timer width; TIMEOUT < 2**TMR_W
//  MAX_RETRY   3    failed trainings tolerated before ERROR (retry_cnt width 2)
// PORTS
//  clk_f            in   1  clock, rising-edge
//  reset_L          in   1  asynchronous, active-low reset
//  enable           in   1  link requested by upper layer (level)
//  rx_active0       in   1  lane0 lock flag from phy_rx (active0)
//  rx_active1       in   1  lane1 lock flag from phy_rx (active1)
//  valid_in         in   1  upstream data valid
//  tx_active_lane0  out  1  lane0 enable to phy_tx
//  tx_active_lane1  out  1  lane1 enable to phy_tx
//  tx_valid         out  1  valid_in gated to phy_tx
//  ready            out  1  link up, upstream may send
//  link_err         out  1  retries exhausted
//  retry_cnt        out  2  failed trainings since last IDLE/LINK_UP
//  state_o          out  3  current state encoding (debug)
// BEHAVIOUR
//  Reset: state=IDLE; timer=0; stable cnt=0; retry_cnt=0; all outputs 0.
//  States (encoding): IDLE=0, TRAIN_L0=1, TRAIN_L1=2, LINK_UP=3, RECOVER=4, ERROR=5; 6,7 -> IDLE.
//  Moore decode from state register: lane0=1 in TRAIN_L0/TRAIN_L1/LINK_UP; lane1=1 in TRAIN_L1/LINK_UP;
//   ready=1 in LINK_UP; link_err=1 in ERROR. tx_valid = valid_in & (state==LINK_UP), combinational, 0 latency.
//  Transition priority each cycle: enable==0 > lane loss > lock > timeout.
//  IDLE: enable=1 -> TRAIN_L0 (lane0 high the cycle after enable sampled).
//  TRAIN_L0: rx_active0 high STABLE_CYC consecutive cycles -> TRAIN_L1; timer==TIMEOUT-1 -> RECOVER.
//  TRAIN_L1: rx_active0 low -> RECOVER; rx_active0&rx_active1 high STABLE_CYC consecutive -> LINK_UP;
//   timeout -> RECOVER. Lock and timeout on same cycle: lock wins.
//  LINK_UP: retry_cnt<=0. rx_active0 or rx_active1 low for 1 cycle -> RECOVER (tx_valid drops same
//   cycle the state leaves). No debounce on loss.
//  RECOVER: both lanes low for STABLE_CYC cycles (quiet), then retry_cnt+1; if new value==MAX_RETRY ->
//   ERROR else TRAIN_L0. retry_cnt saturates at MAX_RETRY.
//  ERROR: sticky; leaves only on enable=0 -> IDLE.
//  enable=0 in any state -> IDLE next cycle; retry_cnt cleared in IDLE.
//  Timer and stable counter clear on every state change; stable counter clears when the watched flag(s) drop.
//  Timer saturates, never wraps. reset_L low mid-training: all outputs 0 immediately (async).
// STRUCTURE
//  phy_link_defs.vh: state encodings, default STABLE_CYC/TIMEOUT/MAX_RETRY.
//  Sub-module phy_stable_cnt: saturating run-length counter (in, clr, locked=count>=STABLE_CYC),
//   instantiated once, reused for lock detect and RECOVER quiet time.
//  Top: state register + next-state logic, timer, retry counter, output decode.
// TESTING (bench: STABLE_CYC=4, TIMEOUT=16, MAX_RETRY=3)
//  1 Reset: reset_L=0 with enable=1, active flags=1 -> all outputs 0, state_o=0 until release.
//  2 Clean bring-up: enable@t0, rx_active0 high from t2, rx_active1 from t8 -> lane0 @t1, lane1 after 4
//    active0 cycles, ready 4 cycles after both high; valid_in pulses pass to tx_valid only while ready.
//  3 Timeout: rx_active0 never rises -> RECOVER after 16 cycles in TRAIN_L0, 4 quiet cycles, retry_cnt=1, retrain.
//  4 Exhaustion: 3 consecutive timeouts -> ERROR, link_err=1, retry_cnt=3; enable=0 -> IDLE, retry_cnt=0.
//  5 Loss: in LINK_UP drop rx_active1 1 cycle -> ready=0 next edge, lanes low 4 cycles, retrain to LINK_UP, retry_cnt=0.
//  6 Corners: lock and timeout same cycle -> TRAIN_L1; enable=0 during RECOVER -> IDLE; active0 glitch at
//    count 3 restarts count.

Source files
------------

// File: rtl/phy_link_ctrl_pkg.sv
// Shared definitions for the two-lane PHY link-training sequencer:
// state encoding, default timing parameters and a retry-count helper.
package phy_link_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TRAIN_L0 = 3'd1,
    ST_TRAIN_L1 = 3'd2,
    ST_LINK_UP  = 3'd3,
    ST_RECOVER  = 3'd4,
    ST_ERROR    = 3'd5
  } link_state_e;

  localparam int unsigned DEF_STABLE_CYC = 4;
  localparam int unsigned DEF_TIMEOUT    = 200;
  localparam int unsigned DEF_TMR_W      = 8;
  localparam int unsigned DEF_MAX_RETRY  = 3;
  localparam int unsigned RETRY_W        = 2;

  // Saturating increment of the failed-training count; never exceeds lim.
  function automatic logic [RETRY_W-1:0] retry_next(input logic [RETRY_W-1:0] cur,
                                                     input logic [RETRY_W-1:0] lim);
    logic [RETRY_W-1:0] nxt;
    if (cur >= lim) begin
      nxt = lim;
    end else begin
      nxt = cur + RETRY_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/phy_link_ctrl_stable_cnt.sv
// Saturating run-length counter: counts consecutive cycles i_in is high.
// o_locked asserts on the cycle the run reaches STABLE_CYC, so a caller can
// act on the very edge that completes the run.
module phy_link_ctrl_stable_cnt #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic clk_f,
  input  logic reset_L,
  input  logic i_in,
  input  logic i_clr,
  output logic o_locked
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  // Run-length register: restarts on clear or when the watched input drops.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      r_cnt <= '0;
    end else if (i_clr || !i_in) begin
      r_cnt <= '0;
    end else if (r_cnt < CNT_SAT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_locked = i_in && (r_cnt >= CNT_PRE);

endmodule

// File: rtl/phy_link_ctrl.sv
// Link-training sequencer for the two-lane PHY. Brings lane0 then lane1 up,
// confirms each through the RX lock flags, gates valid_in into the TX while
// the link is up, retrains on lane loss and latches an error once the retry
// budget is spent.
module phy_link_ctrl
  import phy_link_ctrl_pkg::*;
#(
  parameter int unsigned STABLE_CYC = DEF_STABLE_CYC,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned TMR_W      = DEF_TMR_W,
  parameter int unsigned MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic               clk_f,
  input  logic               reset_L,
  input  logic               enable,
  input  logic               rx_active0,
  input  logic               rx_active1,
  input  logic               valid_in,
  output logic               tx_active_lane0,
  output logic               tx_active_lane1,
  output logic               tx_valid,
  output logic               ready,
  output logic               link_err,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state_o
);

  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   TMR_MAX   = {TMR_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  link_state_e        r_state;
  link_state_e        w_next;
  logic [TMR_W-1:0]   r_tmr;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_inc;
  logic               w_watch;
  logic               w_locked;
  logic               w_state_chg;
  logic               w_timeout;
  logic               w_quiet_done;

  assign w_state_chg  = (w_next != r_state);
  assign w_timeout    = (r_tmr == TMR_LAST);
  assign w_retry_inc  = retry_next(r_retry, RETRY_LIM);
  assign w_quiet_done = (r_state == ST_RECOVER) && enable && w_locked;

  // Select which flag condition the shared run-length counter watches.
  always_comb begin
    w_watch = 1'b0;
    case (r_state)
      ST_TRAIN_L0: w_watch = rx_active0;
      ST_TRAIN_L1: w_watch = rx_active0 & rx_active1;
      ST_RECOVER:  w_watch = ~rx_active0 & ~rx_active1;
      default:     w_watch = 1'b0;
    endcase
  end

  phy_link_ctrl_stable_cnt #(
    .STABLE_CYC (STABLE_CYC)
  ) u_stable_cnt (
    .clk_f    (clk_f),
    .reset_L  (reset_L),
    .i_in     (w_watch),
    .i_clr    (w_state_chg),
    .o_locked (w_locked)
  );

  // State register.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; priority is enable drop, lane loss, lock, timeout.
  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_next = ST_TRAIN_L0;
        ST_TRAIN_L0: begin
          if (w_locked) begin
            w_next = ST_TRAIN_L1;
          end else if (w_timeout) begin
            w_next = ST_RECOVER;
          end else begin
            w_next = r_state;
          end
        end
        ST_TRAIN_L1: begin
          if (!rx_active0) begin
            w_next = ST_RECOVER;
          end else if (w_locked) begin
            w_next = ST_LINK_UP;
          end else if (w_timeout) begin
            w_next = ST_RECOVER;
          end else begin
            w_next = r_state;
          end
        end
        ST_LINK_UP: begin
          if (!rx_active0 || !rx_active1) begin
            w_next = ST_RECOVER;
          end else begin
            w_next = r_state;
          end
        end
        ST_RECOVER: begin
          if (w_locked) begin
            if (w_retry_inc == RETRY_LIM) begin
              w_next = ST_ERROR;
            end else begin
              w_next = ST_TRAIN_L0;
            end
          end else begin
            w_next = r_state;
          end
        end
        ST_ERROR: w_next = ST_ERROR;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // Per-state cycle timer: restarts on every state change, saturates at all-ones.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      r_tmr <= '0;
    end else if (w_state_chg) begin
      r_tmr <= '0;
    end else if (r_tmr != TMR_MAX) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end else begin
      r_tmr <= r_tmr;
    end
  end

  // Failed-training count: cleared while idle or up, bumped when a quiet period completes.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      r_retry <= '0;
    end else if ((r_state == ST_IDLE) || (r_state == ST_LINK_UP)) begin
      r_retry <= '0;
    end else if (w_quiet_done) begin
      r_retry <= w_retry_inc;
    end else begin
      r_retry <= r_retry;
    end
  end

  // Moore output decode from the state register; tx_valid is a zero-latency gate.
  always_comb begin
    tx_active_lane0 = 1'b0;
    tx_active_lane1 = 1'b0;
    ready           = 1'b0;
    link_err        = 1'b0;
    case (r_state)
      ST_TRAIN_L0: tx_active_lane0 = 1'b1;
      ST_TRAIN_L1: begin
        tx_active_lane0 = 1'b1;
        tx_active_lane1 = 1'b1;
      end
      ST_LINK_UP: begin
        tx_active_lane0 = 1'b1;
        tx_active_lane1 = 1'b1;
        ready           = 1'b1;
      end
      ST_ERROR: link_err = 1'b1;
      default: begin
        tx_active_lane0 = 1'b0;
        tx_active_lane1 = 1'b0;
        ready           = 1'b0;
        link_err        = 1'b0;
      end
    endcase
    tx_valid = valid_in & (r_state == ST_LINK_UP);
  end

  assign retry_cnt = r_retry;
  assign state_o   = r_state;

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Bench for phy_link_ctrl: directed scenarios with hand-derived timing plus
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_phy_link_ctrl;

  localparam int STABLE = 4;
  localparam int TOUT   = 16;
  localparam int MAXR   = 3;

  logic       clk_f = 1'b0;
  logic       reset_L;
  logic       enable;
  logic       rx_active0;
  logic       rx_active1;
  logic       valid_in;
  logic       tx_active_lane0;
  logic       tx_active_lane1;
  logic       tx_valid;
  logic       ready;
  logic       link_err;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_mis = 0;

  // behavioural model state: mode number, cycles in mode, run length, retries
  int m_st;
  int m_tmr;
  int m_run;
  int m_retry;

  always #5 clk_f = ~clk_f;

  phy_link_ctrl #(
    .STABLE_CYC (STABLE),
    .TIMEOUT    (TOUT),
    .TMR_W      (8),
    .MAX_RETRY  (MAXR)
  ) dut (
    .clk_f           (clk_f),
    .reset_L         (reset_L),
    .enable          (enable),
    .rx_active0      (rx_active0),
    .rx_active1      (rx_active1),
    .valid_in        (valid_in),
    .tx_active_lane0 (tx_active_lane0),
    .tx_active_lane1 (tx_active_lane1),
    .tx_valid        (tx_valid),
    .ready           (ready),
    .link_err        (link_err),
    .retry_cnt       (retry_cnt),
    .state_o         (state_o)
  );

  function automatic void model_reset();
    m_st = 0; m_tmr = 0; m_run = 0; m_retry = 0;
  endfunction

  // One clock of the link rules, using the inputs sampled at that edge.
  function automatic void model_step(input logic en, input logic a0, input logic a1);
    logic cond;
    logic locked;
    logic tout;
    int   run_now;
    int   nxt;
    int   rt;
    case (m_st)
      1:       cond = a0;
      2:       cond = a0 & a1;
      4:       cond = !a0 & !a1;
      default: cond = 1'b0;
    endcase
    run_now = cond ? m_run + 1 : 0;
    locked  = (run_now >= STABLE);
    tout    = (m_tmr == TOUT - 1);
    nxt = m_st;
    rt  = m_retry;
    if (m_st == 0 || m_st == 3) rt = 0;
    if (!en) begin
      nxt = 0;
    end else begin
      case (m_st)
        0: nxt = 1;
        1: if (locked) nxt = 2; else if (tout) nxt = 4;
        2: if (!a0) nxt = 4; else if (locked) nxt = 3; else if (tout) nxt = 4;
        3: if (!(a0 && a1)) nxt = 4;
        4: if (locked) begin
             rt  = (m_retry < MAXR) ? m_retry + 1 : MAXR;
             nxt = (rt == MAXR) ? 5 : 1;
           end
        5: nxt = 5;
        default: nxt = 0;
      endcase
    end
    if (nxt != m_st) begin
      m_tmr = 0;
      m_run = 0;
    end else begin
      m_tmr = (m_tmr < 255) ? m_tmr + 1 : 255;
      m_run = (run_now < STABLE) ? run_now : STABLE;
    end
    m_st    = nxt;
    m_retry = rt;
  endfunction

  function automatic logic [9:0] model_out(input logic vin);
    logic l0, l1, rd, er;
    l0 = (m_st >= 1 && m_st <= 3);
    l1 = (m_st == 2 || m_st == 3);
    rd = (m_st == 3);
    er = (m_st == 5);
    return {l0, l1, vin & rd, rd, er, 2'(m_retry), 3'(m_st)};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {tx_active_lane0, tx_active_lane1, tx_valid, ready, link_err, retry_cnt, state_o};
  endfunction

  task automatic tick();
    @(posedge clk_f);
    model_step(enable, rx_active0, rx_active1);
    #1;
  endtask

  task automatic go_idle();
    enable = 1'b0; rx_active0 = 1'b0; rx_active1 = 1'b0; valid_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (dut_vec() !== model_out(valid_in) || state_o !== 3'd0) begin
        n_mis++;
        $display("FAIL go_idle k=%0d got %b exp %b", k, dut_vec(), model_out(valid_in));
      end
    end
  endtask

  task automatic test_reset();
    reset_L = 1'b0; enable = 1'b1; rx_active0 = 1'b1; rx_active1 = 1'b1; valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_f); #1;
      n_vec++;
      if (dut_vec() !== 10'd0) begin
        n_mis++;
        $display("FAIL reset_hold k=%0d got %b exp %b", k, dut_vec(), 10'd0);
      end
    end
    reset_L = 1'b1;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      tick();
      n_vec++;
      if (dut_vec() !== model_out(valid_in)) begin
        n_mis++;
        $display("FAIL reset_train k=%0d got %b exp %b", k, dut_vec(), model_out(valid_in));
      end
    end
    #2 reset_L = 1'b0;
    #1;
    n_vec++;
    if (dut_vec() !== 10'd0) begin
      n_mis++;
      $display("FAIL reset_async got %b exp %b", dut_vec(), 10'd0);
    end
    @(posedge clk_f); #1;
    reset_L = 1'b1;
    model_reset();
  endtask

  task automatic test_bringup();
    go_idle();
    for (int e = 0; e <= 15; e++) begin
      enable = 1'b1; rx_active0 = (e >= 2); rx_active1 = (e >= 8);
      valid_in = 1'($urandom_range(0, 1));
      tick();
      n_vec++;
      if (dut_vec() !== model_out(valid_in)) begin
        n_mis++;
        $display("FAIL bringup_model e=%0d got %b exp %b", e, dut_vec(), model_out(valid_in));
      end
      n_vec++;
      if ({tx_active_lane0, tx_active_lane1, ready, tx_valid} !==
          {1'b1, (e >= 5), (e >= 11), valid_in & (e >= 11)}) begin
        n_mis++;
        $display("FAIL bringup_timing e=%0d got l0l1 rdy txv=%b%b%b%b", e,
                 tx_active_lane0, tx_active_lane1, ready, tx_valid);
      end
    end
  endtask

  task automatic test_timeout();
    int exp_st;
    go_idle();
    for (int e = 0; e <= 20; e++) begin
      enable = 1'b1; rx_active0 = 1'b0; rx_active1 = 1'b0;
      valid_in = 1'($urandom_range(0, 1));
      tick();
      exp_st = (e < 16) ? 1 : ((e < 20) ? 4 : 1);
      n_vec++;
      if (dut_vec() !== model_out(valid_in) || state_o !== 3'(exp_st) ||
          retry_cnt !== ((e >= 20) ? 2'd1 : 2'd0)) begin
        n_mis++;
        $display("FAIL timeout e=%0d got %b exp %b state exp %0d", e, dut_vec(),
                 model_out(valid_in), exp_st);
      end
    end
  endtask

  task automatic test_exhaust();
    int exp_st;
    int exp_rt;
    for (int e = 21; e <= 65; e++) begin
      valid_in = 1'($urandom_range(0, 1));
      tick();
      exp_st = (e >= 60) ? 5 : (((e % 20) < 16) ? 1 : 4);
      exp_rt = (e >= 60) ? 3 : e / 20;
      n_vec++;
      if (dut_vec() !== model_out(valid_in) || state_o !== 3'(exp_st) ||
          retry_cnt !== 2'(exp_rt) || link_err !== (e >= 60)) begin
        n_mis++;
        $display("FAIL exhaust e=%0d got %b exp st %0d rt %0d", e, dut_vec(), exp_st, exp_rt);
      end
    end
    enable = 1'b0;
    tick();
    n_vec++;
    if (dut_vec() !== model_out(valid_in) || state_o !== 3'd0 || link_err !== 1'b0) begin
      n_mis++;
      $display("FAIL exhaust_leave got %b exp state 0", dut_vec());
    end
    tick();
    n_vec++;
    if (dut_vec() !== model_out(valid_in) || retry_cnt !== 2'd0) begin
      n_mis++;
      $display("FAIL exhaust_clear got retry %0d exp 0", retry_cnt);
    end
  endtask

  task automatic test_loss();
    int exp_st;
    go_idle();
    for (int e = 0; e <= 11; e++) begin
      enable = 1'b1; rx_active0 = 1'b1; rx_active1 = 1'b1;
      valid_in = 1'($urandom_range(0, 1));
      tick();
      n_vec++;
      if (dut_vec() !== model_out(valid_in) || ready !== (e >= 8)) begin
        n_mis++;
        $display("FAIL loss_up e=%0d got %b exp %b", e, dut_vec(), model_out(valid_in));
      end
    end
    for (int k = 0; k <= 14; k++) begin
      rx_active0 = (k == 0) || (k >= 5);
      rx_active1 = (k >= 5);
      valid_in = 1'($urandom_range(0, 1));
      tick();
      exp_st = (k < 4) ? 4 : ((k < 8) ? 1 : ((k < 12) ? 2 : 3));
      n_vec++;
      if (dut_vec() !== model_out(valid_in) || state_o !== 3'(exp_st) ||
          ready !== (k >= 12) || retry_cnt !== ((k >= 4 && k <= 12) ? 2'd1 : 2'd0)) begin
        n_mis++;
        $display("FAIL loss k=%0d got %b exp state %0d", k, dut_vec(), exp_st);
      end
    end
  endtask

  task automatic test_corners();
    // lock completes on the same edge the timer expires
    go_idle();
    for (int e = 0; e <= 16; e++) begin
      enable = 1'b1; rx_active0 = (e >= 13); rx_active1 = 1'b0; valid_in = 1'b0;
      tick();
      n_vec++;
      if (dut_vec() !== model_out(valid_in) || state_o !== ((e >= 16) ? 3'd2 : 3'd1)) begin
        n_mis++;
        $display("FAIL corner_lock_vs_timeout e=%0d got %b", e, dut_vec());
      end
    end
    // lane loss into RECOVER, then enable drop mid-quiet
    for (int e = 17; e <= 20; e++) begin
      enable = (e < 19); rx_active0 = 1'b0;
      tick();
      n_vec++;
      if (dut_vec() !== model_out(valid_in) || state_o !== ((e < 19) ? 3'd4 : 3'd0) ||
          retry_cnt !== 2'd0) begin
        n_mis++;
        $display("FAIL corner_recover_disable e=%0d got %b", e, dut_vec());
      end
    end
    // lock run broken after three cycles restarts the count
    for (int e = 0; e <= 8; e++) begin
      enable = 1'b1; rx_active0 = (e != 0) && (e != 4);
      tick();
      n_vec++;
      if (dut_vec() !== model_out(valid_in) || state_o !== ((e >= 8) ? 3'd2 : 3'd1)) begin
        n_mis++;
        $display("FAIL corner_glitch e=%0d got %b", e, dut_vec());
      end
    end
  endtask

  task automatic test_random();
    go_idle();
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (enable) begin
        if ($urandom_range(0, 199) == 0) enable = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) enable = 1'b1;
      end
      if ($urandom_range(0, 11) == 0) rx_active0 = ~rx_active0;
      if ($urandom_range(0, 11) == 0) rx_active1 = ~rx_active1;
      valid_in = 1'($urandom_range(0, 1));
      tick();
      n_vec++;
      if (dut_vec() !== model_out(valid_in)) begin
        n_mis++;
        $display("FAIL random i=%0d got %b exp %b", i, dut_vec(), model_out(valid_in));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_bringup();
    test_timeout();
    test_exhaust();
    test_loss();
    test_corners();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
